// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register numbers, exception type codes used by the
// controller and mem stage, Cause.ExcCode values, and the common bus widths.
// decode_exc maps a mem-stage exception type onto its ExcCode.
package cp0_reg_pkg;

    typedef logic [31:0] RegBus;

    localparam logic  RstEnable   = 1'b1;
    localparam logic  WriteEnable = 1'b1;
    localparam RegBus ZeroWord    = '0;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    localparam RegBus EXC_INTERRUPT    = 32'h0000_0001;
    localparam RegBus EXC_SYSCALL      = 32'h0000_0008;
    localparam RegBus EXC_INST_INVALID = 32'h0000_000a;
    localparam RegBus EXC_TRAP         = 32'h0000_000d;
    localparam RegBus EXC_OVERFLOW     = 32'h0000_000c;
    localparam RegBus EXC_ERET         = 32'h0000_000e;

    localparam logic [4:0] EXCCODE_INT = 5'd0;
    localparam logic [4:0] EXCCODE_SYS = 5'd8;
    localparam logic [4:0] EXCCODE_RI  = 5'd10;
    localparam logic [4:0] EXCCODE_OV  = 5'd12;
    localparam logic [4:0] EXCCODE_TR  = 5'd13;

    typedef struct packed {
        logic       hit;
        logic [4:0] exccode;
    } exc_decode_t;

    // eret is not listed here: it only clears EXL and is handled separately.
    function automatic exc_decode_t decode_exc(input RegBus excepttype);
        exc_decode_t d;
        d.hit     = 1'b1;
        d.exccode = EXCCODE_INT;
        case (excepttype)
            EXC_INTERRUPT:    d.exccode = EXCCODE_INT;
            EXC_SYSCALL:      d.exccode = EXCCODE_SYS;
            EXC_INST_INVALID: d.exccode = EXCCODE_RI;
            EXC_TRAP:         d.exccode = EXCCODE_TR;
            EXC_OVERFLOW:     d.exccode = EXCCODE_OV;
            default:          d.hit     = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// mtc0/mfc0 access bus between the pipeline and the CP0 register file.
//   we_i/waddr_i/data_i : mtc0 write from writeback
//   raddr_i/data_o      : mfc0 combinational read
interface cp0_reg_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output we_i, output waddr_i, output raddr_i, output data_i, input data_o);
    modport slave  (input we_i, input waddr_i, input raddr_i, input data_i, output data_o);
endinterface

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count, Compare, Status, Cause, EPC, PRId, Config.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   bus (slave)            mtc0 write / mfc0 read access
//   int_i                  external interrupt lines, sampled into Cause.IP[7:2]
//   excepttype_i           mem-stage exception type (0 = none)
//   current_inst_addr_i    PC of the excepting instruction
//   is_in_delayslot_i      excepting instruction sits in a delay slot
//   *_o                    register contents; timer_int_o = timer interrupt pending
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter RegBus PRID_VAL   = 32'h004c0102,
    parameter RegBus CONFIG_VAL = 32'h00008000
) (
    input  logic       clk,
    input  logic       rst,
    cp0_reg_if.slave   bus,
    input  logic [5:0] int_i,
    input  RegBus      excepttype_i,
    input  RegBus      current_inst_addr_i,
    input  logic       is_in_delayslot_i,
    output RegBus      count_o,
    output RegBus      compare_o,
    output RegBus      status_o,
    output RegBus      cause_o,
    output RegBus      epc_o,
    output RegBus      config_o,
    output RegBus      prid_o,
    output logic       timer_int_o
);

    exc_decode_t exc;

    always_comb exc = decode_exc(excepttype_i);

    assign config_o = CONFIG_VAL;
    assign prid_o   = PRID_VAL;

    // Updates are ordered so later assignments win: increment, then mtc0,
    // then exception fields, which therefore override an mtc0 to the same bit.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count_o     <= ZeroWord;
            compare_o   <= ZeroWord;
            status_o    <= 32'h1000_0000;
            cause_o     <= ZeroWord;
            epc_o       <= ZeroWord;
            timer_int_o <= 1'b0;
        end else begin
            count_o        <= count_o + 32'd1;
            cause_o[15:10] <= int_i;

            if (compare_o != ZeroWord && count_o == compare_o)
                timer_int_o <= 1'b1;

            if (bus.we_i == WriteEnable) begin
                case (bus.waddr_i)
                    CP0_REG_COUNT:   count_o <= bus.data_i;
                    CP0_REG_COMPARE: begin
                        compare_o   <= bus.data_i;
                        timer_int_o <= 1'b0;
                    end
                    CP0_REG_STATUS:  status_o <= bus.data_i;
                    CP0_REG_EPC:     epc_o    <= bus.data_i;
                    CP0_REG_CAUSE: begin
                        cause_o[9:8]   <= bus.data_i[9:8];
                        cause_o[23:22] <= bus.data_i[23:22];
                    end
                    default: ;
                endcase
            end

            if (exc.hit) begin
                // A nested non-interrupt exception keeps the original EPC/BD.
                if (!status_o[1] || excepttype_i == EXC_INTERRUPT) begin
                    if (is_in_delayslot_i) begin
                        epc_o      <= current_inst_addr_i - 32'd4;
                        cause_o[31] <= 1'b1;
                    end else begin
                        epc_o      <= current_inst_addr_i;
                        cause_o[31] <= 1'b0;
                    end
                end
                status_o[1]  <= 1'b1;
                cause_o[6:2] <= exc.exccode;
            end else if (excepttype_i == EXC_ERET) begin
                status_o[1] <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.data_o = ZeroWord;
        if (rst != RstEnable) begin
            case (bus.raddr_i)
                CP0_REG_COUNT:   bus.data_o = count_o;
                CP0_REG_COMPARE: bus.data_o = compare_o;
                CP0_REG_STATUS:  bus.data_o = status_o;
                CP0_REG_CAUSE:   bus.data_o = cause_o;
                CP0_REG_EPC:     bus.data_o = epc_o;
                CP0_REG_PRID:    bus.data_o = prid_o;
                CP0_REG_CONFIG:  bus.data_o = config_o;
                default:         bus.data_o = ZeroWord;
            endcase
        end
    end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file for the 5-stage MIPS32 core.
- Holds Count, Compare, Status, Cause, EPC, PRId and Config.
- Services mtc0 writes and mfc0 reads, and latches exception state: EPC, Cause.ExcCode, Cause.BD, Status.EXL.
- Feeds the pipeline controller's EPC input (epc_o, used for eret), feeds the mem-stage exception check (status_o/cause_o), and generates the timer interrupt.

Parameters:
- PRID_VAL, 32'h004c0102, read-only PRId contents.
- CONFIG_VAL, 32'h00008000, read-only Config contents (BE=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- we_i  in  1  mtc0 write enable (from writeback).
- waddr_i  in  5  CP0 write register number.
- raddr_i  in  5  CP0 read register number.
- data_i  in  32  mtc0 write data.
- int_i  in  6  external hardware interrupt lines.
- excepttype_i  in  32  exception code from mem stage; 0 = none.
- current_inst_addr_i  in  32  PC of the excepting instruction.
- is_in_delayslot_i  in  1  excepting instruction is in a delay slot.
- data_o  out  32  mfc0 read data.
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  register contents.
- timer_int_o  out  1  timer interrupt pending.

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active high.
- Reset values:
  - count_o = 0, compare_o = 0, cause_o = 0, epc_o = 0, timer_int_o = 0.
  - status_o = 32'h10000000 (CU0 = 1).
  - config_o = CONFIG_VAL, prid_o = PRID_VAL.
  - data_o = 0 while rst.
- Count: increments by 1 every non-reset cycle and wraps 32'hFFFFFFFF -> 0. An mtc0 to Count overrides the increment that cycle.
- Timer interrupt:
  - Set timer_int_o = 1 on the cycle after count_o == compare_o with compare_o != 0.
  - timer_int_o stays set until an mtc0 to Compare, which also clears it in that same cycle.
- Cause.IP[7:2] (bits 15:10) is registered from int_i every cycle.
- mtc0 register decode (registered, effective next cycle):
  - 9: Count.
  - 11: Compare.
  - 12: Status, full 32 bits.
  - 14: EPC.
  - 13: Cause, writable bits only: IP[1:0] (9:8), IV (23), WP (22). All other Cause bits are unchanged.
  - 15, 16 and all other addresses: ignored.
- Exception update: same cycle as excepttype_i != 0. It takes priority over an mtc0 to the same field in that cycle; mtc0 to unaffected fields still commits.
- Exception code table:
  - 0x01 interrupt, ExcCode 0.
  - 0x08 syscall, ExcCode 8.
  - 0x0a invalid instruction, ExcCode 10.
  - 0x0d trap, ExcCode 13.
  - 0x0c overflow, ExcCode 12.
- For every code in the table:
  - If Status.EXL == 0, or the code is 0x01:
    - EPC = current_inst_addr_i − 4 and Cause.BD = 1 when is_in_delayslot_i;
    - otherwise EPC = current_inst_addr_i and Cause.BD = 0.
  - If Status.EXL == 1 and the code is not 0x01: EPC and BD are untouched.
  - Then set Status.EXL = 1 and Cause[6:2] = ExcCode.
- 0x0e eret: Status.EXL = 0. Nothing else changes.
- Other nonzero codes: no state change.
- Read path:
  - data_o is combinational from raddr_i over registers 9, 11, 12, 13, 14, 15, 16; others read 0.
  - No internal write-to-read bypass; forwarding of in-flight mtc0 is done in the mem/wb stages.
- Width rule: EPC arithmetic is modulo 2^32 (address 0 in a delay slot gives 32'hFFFFFFFC).
- Reset mid-operation: rst overrides any pending write or exception in that cycle.

Decomposition:
- Shared defines package:
  - CP0 register numbers: CP0_REG_COUNT = 9, COMPARE = 11, STATUS = 12, CAUSE = 13, EPC = 14, PRID = 15, CONFIG = 16.
  - Exception type codes 0x01/0x08/0x0a/0x0d/0x0c/0x0e, shared with the controller and mem stage.
  - ExcCode values.
  - Existing RstEnable, WriteEnable, ZeroWord, RegBus.
- No sub-module. A single module with one clocked process and one combinational read process.

Test Plan:
- Reset: assert rst 2 cycles → status_o = 32'h10000000, prid_o = 32'h004c0102, count_o = 0, data_o = 0. Release → count_o = 1 after the first edge.
- Timer: mtc0 Compare = 5 while Count = 0 → timer_int_o rises exactly one cycle after count_o == 5. Then mtc0 Compare = 20 → timer_int_o = 0 next cycle.
- Syscall in delay slot: EXL = 0, excepttype_i = 0x08, addr = 0x100, delayslot = 1 → epc_o = 0xFC, cause_o[31] = 1, cause_o[6:2] = 8, status_o[1] = 1.
- Nested syscall, then interrupt: EXL = 1, excepttype_i = 0x08 at addr 0x200 → epc_o unchanged. Then excepttype_i = 0x01 at addr 0x300, no delay slot → epc_o = 0x300, ExcCode = 0.
- Eret with simultaneous mtc0: excepttype_i = 0x0e → status_o[1] = 0. Separately, mtc0 EPC = 0x400 in the same cycle as a 0x0c exception at addr 0x500 → epc_o = 0x500.
- Cause masking: mtc0 Cause = 32'hFFFFFFFF with int_i = 6'b000001 → cause_o = 32'h00C00700 (IP1:0 plus IV/WP, IP2 from int_i).
